jpeg_rle_encoder: RTL
=====================

// Module: jpeg_rle_encoder
// PURPOSE
//  Run-length/category encoder sitting directly downstream of the JPEG quantizer
//  datapath. It consumes one block of 64 quantized coefficients in zig-zag order.
//  It emits JPEG entropy symbols (run, size, amplitude) to the Huffman stage:
//  a DC difference symbol, AC symbols, ZRL (F/0) and EOB (0/0).
// PARAMETERS
//  COEF_W  12  signed quantized coefficient width (two's complement)
// PORTS
//  clk        in   1         single clock, rising edge
//  rst        in   1         asynchronous, active-high reset
//  dc_clear   in   1         pulse: zero the DC predictor (restart interval / new component)
//  in_valid   in   1         coefficient valid
//  in_ready   out  1         coefficient accepted when in_valid & in_ready
//  in_coef    in   COEF_W    quantized coefficient, zig-zag order, index 0 = DC
//  out_valid  out  1         symbol valid
//  out_ready  in   1         symbol consumed when out_valid & out_ready
//  out_dc     out  1         symbol is the DC difference
//  out_run    out  4         zero-run length (0..15)
//  out_size   out  4         magnitude category (0..COEF_W)
//  out_amp    out  COEF_W+1  amplitude bits, LSB-aligned, bits above out_size are 0
//  out_last   out  1         final symbol of the block (EOB or coef 63)
// BEHAVIOUR
//  - Reset: every output 0 except in_ready=1. pred=0, idx=0, run=0, state ACCEPT.
//  - Output register holds one symbol. out_* stay stable while out_valid & !out_ready.
//  - in_ready = (state==ACCEPT) & (!out_valid | out_ready).
//  - Symbol appears on out_* the cycle after the accepting handshake.
//    Throughput is 1 coef/cycle except during ZRL stalls.
//  - idx (6b) increments on every accepted coef and wraps 63->0.
//  - DC (idx 0): diff = coef - pred, computed at COEF_W+1 bits. pred <= coef.
//    Emit out_dc=1, run=0, size=cat(diff). A zero diff gives size 0 and amp 0.
//  - AC zero, idx<63: run++, no symbol emitted.
//  - AC nonzero, run<16: emit run, size=cat(coef), amp. Then run<=0.
//  - AC nonzero, run>=16: latch coef in hold register, emit ZRL (run=15, size=0),
//    run-=16, go to ZRL state.
//  - ZRL state, output slot free: if run>=16, emit another ZRL and run-=16.
//    Otherwise emit the held symbol with the remaining run, run<=0, return to ACCEPT.
//  - Max run is 62, so at most 3 ZRLs.
//  - idx 63 zero: emit EOB (run=0, size=0, out_last=1). Pending run and ZRLs are
//    discarded; no ZRL ever precedes an EOB.
//  - idx 63 nonzero: emit its symbol with out_last=1, after any required ZRLs.
//    No EOB follows.
//  - cat(v) = bit length of |v|.
//    amp = v for v>0. For v<0, amp = (v-1) truncated to cat(v) bits (JPEG ones'-complement).
//  - dc_clear: pred<=0 next edge. If it coincides with a DC accept, that DC uses pred=0.
//    Mid-block assertion affects the next block's DC only.
//  - Async reset mid-block aborts it. The next accepted coef is treated as DC.
// STRUCTURE
//  - Package jpeg_rle_pkg: COEF_W default, ZRL/EOB run/size constants, a packed
//    rle_sym_t struct {dc, run, size, amp, last}, and the state enum {ACCEPT, ZRL}.
//  - One combinational sub-module jpeg_mag_category (value -> size, amp), instanced once
//    and fed from a mux of diff / in_coef / hold register.
// TESTING
//  1. All-zero block after reset -> DC(size0, amp0), then EOB with out_last=1;
//     exactly 2 symbols.
//  2. DC 5 then DC -3 in the next block -> (dc, size3, amp101); then diff -8 ->
//     (dc, size4, amp0111).
//  3. AC: idx1=0, idx2=0, idx3=-1 -> (run2, size1, amp0); rest zero -> EOB.
//  4. 40 zeros then nonzero 3 at idx41 -> ZRL, ZRL, then (run8, size2, amp11).
//     in_ready low for 2 cycles.
//  5. Only idx63 = 1 -> 3 ZRLs, then (run14, size1, amp1, last); no EOB.
//  6. Random out_ready backpressure and dc_clear coinciding with DC -> symbol
//     stream matches the golden model; out_* stable while stalled.

Source files
------------

// File: rtl/jpeg_rle_pkg.sv
// Shared types and constants for the JPEG run-length/category encoder.
// Symbol bundle, ZRL/EOB encodings and the encoder state enum.
package jpeg_rle_pkg;

  localparam int COEF_W = 12;

  localparam logic [3:0] ZRL_RUN  = 4'd15;
  localparam logic [3:0] ZRL_SIZE = 4'd0;
  localparam logic [3:0] EOB_RUN  = 4'd0;
  localparam logic [3:0] EOB_SIZE = 4'd0;

  typedef struct packed {
    logic            dc;
    logic [3:0]      run;
    logic [3:0]      size;
    logic [COEF_W:0] amp;
    logic            last;
  } rle_sym_t;

  typedef enum logic {
    ACCEPT = 1'b0,
    ZRL    = 1'b1
  } state_t;

endpackage

// File: rtl/jpeg_mag_category.sv
// Magnitude category and JPEG amplitude bits of a signed value.
// Negative values use the ones'-complement form (v-1) truncated to size bits.
module jpeg_mag_category #(
  parameter int W = 12
) (
  input  logic [W:0] val,
  output logic [3:0] size,
  output logic [W:0] amp
);

  localparam logic [W:0] ONE = {{W{1'b0}}, 1'b1};

  logic [W:0] mag;
  logic [W:0] mask;
  logic [W:0] raw;

  always_comb begin
    mag  = val[W] ? (~val + ONE) : val;
    size = 4'd0;
    for (int i = 0; i <= W; i++) begin
      if (mag[i]) size = 4'(i + 1);
    end
    mask = (ONE << size) - ONE;
    raw  = val[W] ? (val - ONE) : val;
    amp  = raw & mask;
  end

endmodule

// File: rtl/jpeg_rle_encoder.sv
// Run-length/category encoder: zig-zag coefficients in, JPEG
// DC/AC/ZRL/EOB symbols out through a one-deep output register.
module jpeg_rle_encoder
  import jpeg_rle_pkg::*;
#(
  parameter int COEF_W = jpeg_rle_pkg::COEF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dc_clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_coef,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_dc,
  output logic [3:0]        out_run,
  output logic [3:0]        out_size,
  output logic [COEF_W:0]   out_amp,
  output logic              out_last
);

  state_t            state, state_n;
  logic [5:0]        idx, run;
  logic [COEF_W-1:0] pred, hold, pred_eff;
  logic              hold_last;
  logic              slot_free, acc, zrl_go;
  logic              is_dc, is_last, nz, long_run;
  logic [COEF_W:0]   diff, cat_in, cat_amp;
  logic [3:0]        cat_size;
  logic              emit;
  rle_sym_t          sym_q, sym_n;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state == ACCEPT) && slot_free;
  assign acc       = in_valid && in_ready;
  assign zrl_go    = (state == ZRL) && slot_free;
  assign is_dc     = idx == 6'd0;
  assign is_last   = idx == 6'd63;
  assign nz        = |in_coef;
  assign long_run  = |run[5:4];

  // A coincident dc_clear makes this block's DC predict from zero.
  assign pred_eff = dc_clear ? '0 : pred;
  assign diff = {in_coef[COEF_W-1], in_coef}
              - {pred_eff[COEF_W-1], pred_eff};

  always_comb begin
    if (state == ZRL) cat_in = {hold[COEF_W-1], hold};
    else if (is_dc)   cat_in = diff;
    else              cat_in = {in_coef[COEF_W-1], in_coef};
  end

  jpeg_mag_category #(.W(COEF_W)) u_cat (
    .val  (cat_in),
    .size (cat_size),
    .amp  (cat_amp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCEPT;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ACCEPT: if (acc && !is_dc && nz && long_run) state_n = ZRL;
      ZRL:    if (slot_free && !long_run) state_n = ACCEPT;
      default: state_n = ACCEPT;
    endcase
  end

  always_comb begin
    emit  = 1'b0;
    sym_n = '0;
    unique case (1'b1)
      acc: begin
        emit = is_dc || nz || is_last;
        if (is_dc) begin
          sym_n.dc   = 1'b1;
          sym_n.size = cat_size;
          sym_n.amp  = cat_amp;
        end else if (nz && long_run) begin
          sym_n.run  = ZRL_RUN;
          sym_n.size = ZRL_SIZE;
        end else if (nz) begin
          sym_n.run  = run[3:0];
          sym_n.size = cat_size;
          sym_n.amp  = cat_amp;
          sym_n.last = is_last;
        end else begin
          sym_n.run  = EOB_RUN;
          sym_n.size = EOB_SIZE;
          sym_n.last = 1'b1;
        end
      end
      zrl_go: begin
        emit = 1'b1;
        if (long_run) begin
          sym_n.run  = ZRL_RUN;
          sym_n.size = ZRL_SIZE;
        end else begin
          sym_n.run  = run[3:0];
          sym_n.size = cat_size;
          sym_n.amp  = cat_amp;
          sym_n.last = hold_last;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      run       <= '0;
      pred      <= '0;
      hold      <= '0;
      hold_last <= 1'b0;
    end else begin
      if (dc_clear) pred <= '0;
      if (acc) begin
        idx <= idx + 6'd1;
        if (is_dc) begin
          pred <= in_coef;
          run  <= '0;
        end else if (nz && long_run) begin
          hold      <= in_coef;
          hold_last <= is_last;
          run       <= run - 6'd16;
        end else if (nz || is_last) begin
          run <= '0;
        end else begin
          run <= run + 6'd1;
        end
      end
      if (zrl_go) run <= long_run ? run - 6'd16 : 6'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sym_q     <= '0;
    end else if (emit) begin
      out_valid <= 1'b1;
      sym_q     <= sym_n;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_dc   = sym_q.dc;
  assign out_run  = sym_q.run;
  assign out_size = sym_q.size;
  assign out_amp  = sym_q.amp;
  assign out_last = sym_q.last;

endmodule
